bcd_seg7_scan: RTL
==================

Name: bcd_seg7_scan

Overview:
- Downstream consumer of the binary-to-BCD converter.
- Captures four BCD digits (thousands/hundreds/tens/ones) on a load strobe and time-multiplexes them onto a common-segment 4-digit seven-segment display.
- Drives digit enables and segment lines, with a blanking gap between digits to suppress ghosting.
- Sits between the BCD converter outputs and the board display pins.

Parameters:
- CLK_DIV, 50000, clock cycles per digit slot (digit dwell time); legal range >= BLANK_CYCLES+2.
- BLANK_CYCLES, 16, cycles at the start of each slot with all digit enables inactive.
- ACTIVE_LOW, 1, 1 = an/seg outputs active-low; 0 = active-high.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- load  input  1  single-cycle strobe; captures the four digit inputs.
- thousands  input  4  BCD digit 3.
- hundreds  input  4  BCD digit 2.
- tens  input  4  BCD digit 1.
- ones  input  4  BCD digit 0.
- an  output  4  digit enables; an[i] drives digit i (0 = ones).
- seg  output  7  segments; seg[0]=a … seg[6]=g.
- frame_tick  output  1  one-cycle pulse when the scan wraps from digit 3 to digit 0.

Behaviour:
- Clock and reset: one clock domain (clk); reset is asynchronous and active-high (rst).
- Reset values: all registers cleared.
  - Latched digits = 0, prescaler = 0, digit index = 0.
  - an = all inactive (4'hF if ACTIVE_LOW). seg = all off (7'h7F if ACTIVE_LOW). frame_tick = 0.
- Reset asserted mid-scan forces the reset values immediately. Scan restarts at digit 0, slot cycle 0, after deassertion.
- Capture: on a clk edge with load=1, all four digits are registered together.
  - An unchanged display is never partially updated.
  - load held high re-captures every cycle.
- Prescaler: counts 0..CLK_DIV-1. At the terminal count it wraps to 0 and the digit index advances 0→1→2→3→0.
- frame_tick: asserted for exactly the cycle after the index transitions 3→0. One pulse per 4*CLK_DIV cycles.
- Blanking: while prescaler < BLANK_CYCLES, an is all inactive. Otherwise exactly one an bit, the current index, is active.
- seg and an are registered outputs.
  - Both reflect prescaler/index/latched digits one cycle later.
  - New data captured by load appears on seg no later than the next active portion of the affected digit's slot.
- Decode (before polarity inversion, 1 = segment lit):
  - 0..9 use standard patterns, e.g. 0=7'h3F, 1=7'h06, 8=7'h7F.
  - Codes 10..15 show dash (g only, 7'h40).
  - seg is driven with the decoded pattern during blanking too, but is not visible because an is inactive.
- Simultaneous load and index advance in the same cycle: the new index and new data take effect together on the next registered output.
- Polarity: ACTIVE_LOW inverts an and seg at the output register. The internal logic is polarity-independent.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: a digit whose value is 0 and all of whose more-significant digits are 0 is shown with all segments off.
  - Ones digit is never blanked, so value 0 shows "0".
  - Example: 0,0,4,2 shows "  42".
  - Blanking uses the latched digits.
- Undefined: all four digits are always shown, e.g. "0042".

Decomposition:
- Shared package seg7_pkg:
  - Segment pattern constants SEG_0..SEG_9, SEG_DASH, SEG_OFF.
  - Digit-index type (2 bits).
  - NUM_DIGITS=4.
- One sub-module: seg7_decode, a combinational 4-bit code → 7-bit active-high pattern using the package constants.
- The top holds the capture, prescaler, scan, blanking, polarity and feature logic.

Test Plan:
- Reset check (CLK_DIV=8, BLANK_CYCLES=2, ACTIVE_LOW=1): assert rst mid-slot → an=4'hF, seg=7'h7F, frame_tick=0 immediately. After release, first active an=4'b1110 at cycle BLANK_CYCLES+1.
- Basic scan: load digits 1,2,3,4 → over one frame, the an sequence 1110/1101/1011/0111 shows seg = ~SEG_4, ~SEG_3, ~SEG_2, ~SEG_1. Each slot lasts 8 cycles, with 2 cycles of an=4'hF at the start.
- Frame tick: run 3 frames → exactly 3 frame_tick pulses, spaced 32 cycles apart, each one cycle wide.
- Invalid code: load thousands=4'hC → digit 3 shows ~7'h40 (dash). Other digits are unaffected.
- Load during active slot: load 9,9,9,9 then 0,0,0,7 while digit 0 is active → the next registered seg shows ~SEG_7. No frame shows a mix of old and new values in a single digit slot.
- Feature: with LEADING_ZERO_BLANK_EN, load 0,0,0,0 → digits 3..1 show seg=7'h7F, digit 0 shows ~SEG_0. Load 0,1,0,5 → only digit 3 is blanked. Without the macro, all four digits show decoded values.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the four-digit seven-segment scanner.
//
// Contents:
//   NUM_DIGITS        number of display digits (4)
//   digit_idx_t       2-bit scan index type (0 = ones ... 3 = thousands)
//   SEG_0..SEG_9      active-high segment patterns, bit 0 = a ... bit 6 = g
//   SEG_DASH          pattern for non-BCD codes (g only)
//   SEG_OFF           all segments dark
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [1:0] digit_idx_t;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/bcd_seg7_scan_if.sv
// Bundle between the BCD converter, the scanner and the display pins.
//
// Signals:
//   load                       single-cycle capture strobe (converter -> scanner)
//   thousands/hundreds/tens/ones  BCD digits 3..0 (converter -> scanner)
//   an[3:0]                    digit enables, an[i] drives digit i
//   seg[6:0]                   segment lines, seg[0]=a ... seg[6]=g
//   frame_tick                 one-cycle pulse on scan wrap 3 -> 0
//   dbg_idx                    current scan index, for observation only
//
// Handshake: load is a fire-and-forget strobe with no ready; the digits are
// sampled on every clk edge where load is 1, and the scanner can always take
// them, so there is no back-pressure and no transaction is ever dropped.
//
// Modports: master = digit source / observer, slave = scanner.
interface bcd_seg7_scan_if;
    import seg7_pkg::*;

    logic       load;
    logic [3:0] thousands;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
    logic [3:0] an;
    logic [6:0] seg;
    logic       frame_tick;
    digit_idx_t dbg_idx;

    modport master (
        output load, thousands, hundreds, tens, ones,
        input  an, seg, frame_tick, dbg_idx
    );

    modport slave (
        input  load, thousands, hundreds, tens, ones,
        output an, seg, frame_tick, dbg_idx
    );

endinterface

// File: rtl/seg7_decode.sv
// Combinational BCD code to seven-segment pattern decoder.
//
// Ports:
//   code     input  4  digit code; 0..9 decode normally, 10..15 show a dash
//   pattern  output 7  active-high segments, bit 0 = a ... bit 6 = g
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_DASH;
        case (code)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_seg7_scan.sv
// Four-digit multiplexed seven-segment scanner.
//
// Captures four BCD digits on a load strobe and scans them onto a
// common-segment display, one digit per CLK_DIV-cycle slot, with the first
// BLANK_CYCLES cycles of every slot dark to suppress ghosting.
//
// Ports:
//   clk   input   system clock
//   rst   input   asynchronous active-high reset
//   bus   slave   bcd_seg7_scan_if (load, digits in; an, seg, frame_tick,
//                 dbg_idx out)
//
// Parameters:
//   CLK_DIV       cycles per digit slot, must be >= BLANK_CYCLES+2
//   BLANK_CYCLES  dark cycles at the start of each slot
//   ACTIVE_LOW    1 = an/seg active-low, 0 = active-high
//
// Optional build macro:
//   LEADING_ZERO_BLANK_EN  when defined, leading zero digits (never the ones
//                          digit) are shown with all segments off.
module bcd_seg7_scan
    import seg7_pkg::*;
#(
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 16,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic            clk,
    input  logic            rst,
    bcd_seg7_scan_if.slave  bus
);

    localparam int              PW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0]   BLANK_END  = PW'(BLANK_CYCLES);
    localparam logic            INV        = (ACTIVE_LOW != 0);
    localparam logic [3:0]      AN_IDLE    = INV ? 4'hF : 4'h0;
    localparam logic [6:0]      SEG_IDLE   = INV ? 7'h7F : 7'h00;

    logic [NUM_DIGITS-1:0][3:0] digits_q;
    logic [PW-1:0]              presc_q;
    digit_idx_t                 idx_q;
    logic [3:0]                 an_q;
    logic [6:0]                 seg_q;
    logic                       tick_q;

    logic                       slot_end;
    logic [3:0]                 cur_code;
    logic [6:0]                 dec_pattern;
    logic                       lead_zero;
    logic [3:0]                 an_lit;
    logic [6:0]                 seg_lit;

    // All four digits are registered in the same edge so a digit slot can
    // never show a mix of old and new values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digits_q <= '0;
        end else if (bus.load) begin
            digits_q <= {bus.thousands, bus.hundreds, bus.tens, bus.ones};
        end
    end

    assign slot_end = (presc_q == PRESC_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            idx_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            if (slot_end) begin
                presc_q <= '0;
                idx_q   <= idx_q + 2'd1;
            end else begin
                presc_q <= presc_q + PW'(1);
            end
            // Registered so it is high in the first cycle of digit 0's slot.
            tick_q <= slot_end && (idx_q == 2'd3);
        end
    end

    assign cur_code = digits_q[idx_q];

    seg7_decode u_decode (
        .code    (cur_code),
        .pattern (dec_pattern)
    );

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is dark when it and every more-significant digit are zero;
    // the ones digit always shows so that a value of 0 reads "0".
    always_comb begin
        lead_zero = 1'b0;
        case (idx_q)
            2'd3:    lead_zero = (digits_q[3] == 4'd0);
            2'd2:    lead_zero = (digits_q[3] == 4'd0) && (digits_q[2] == 4'd0);
            2'd1:    lead_zero = (digits_q[3] == 4'd0) && (digits_q[2] == 4'd0)
                              && (digits_q[1] == 4'd0);
            default: lead_zero = 1'b0;
        endcase
    end
`else
    assign lead_zero = 1'b0;
`endif

    // Internal view is active-high; polarity is applied only at the output
    // register. Segments carry the decoded digit even while blanked, since
    // the dark enables already hide them.
    assign an_lit  = (presc_q < BLANK_END) ? 4'b0000 : (4'b0001 << idx_q);
    assign seg_lit = lead_zero ? SEG_OFF : dec_pattern;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_q  <= AN_IDLE;
            seg_q <= SEG_IDLE;
        end else begin
            an_q  <= an_lit ^ {4{INV}};
            seg_q <= seg_lit ^ {7{INV}};
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.frame_tick = tick_q;
    assign bus.dbg_idx    = idx_q;

endmodule
